// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the cache controllers, the arbiter and the shared memory.
// slave = arbiter side, master = cache/memory side (testbench or wrapper).
interface mem_bus_arbiter_if #(
   parameter int NREQ   = 3,
   parameter int TAG_W  = 2,
   parameter int DATA_W = 2
);
   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        we_in;
   logic [NREQ*TAG_W-1:0]  tag_in;
   logic [NREQ*DATA_W-1:0] data_in;
   logic [NREQ-1:0]        gnt;
   logic                   done;
   logic [DATA_W-1:0]      rdata;
   logic [TAG_W-1:0]       mem_tag;
   logic [DATA_W-1:0]      mem_data;
   logic                   mem_writeEn;
   logic [DATA_W-1:0]      mem_Q;
   logic                   snoop_valid;
   logic                   snoop_we;
   logic [TAG_W-1:0]       snoop_tag;
   logic [NREQ-1:0]        snoop_src;

   modport slave (
      input  req, we_in, tag_in, data_in, mem_Q,
      output gnt, done, rdata, mem_tag, mem_data, mem_writeEn,
             snoop_valid, snoop_we, snoop_tag, snoop_src
   );

   modport master (
      output req, we_in, tag_in, data_in, mem_Q,
      input  gnt, done, rdata, mem_tag, mem_data, mem_writeEn,
             snoop_valid, snoop_we, snoop_tag, snoop_src
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory among NREQ caches.
// Optional bus-transaction broadcast for snooping is built when BUS_SNOOP_EN is defined.
module mem_bus_arbiter #(
   parameter int NREQ   = 3,
   parameter int TAG_W  = 2,
   parameter int DATA_W = 2
) (
   input logic              clk,
   input logic              rst,
   mem_bus_arbiter_if.slave bus
);
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, READ, DONE} state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  last, winner;
   logic              any_req;
   logic              lat_we;
   logic [TAG_W-1:0]  lat_tag;
   logic [DATA_W-1:0] lat_data;
   logic [NREQ-1:0]   gnt_r;
   logic [DATA_W-1:0] rdata_r;

   assign any_req = |bus.req;

   // Search starts one past the previous winner so a cache that keeps req high
   // is served again only after every other pending requester.
   always_comb begin
      int  cand;
      logic found;
      winner = last;
      found  = 1'b0;
      cand   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(last) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!found && bus.req[cand]) begin
            winner = IDX_W'(cand);
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  state_nxt = lat_we ? DONE : READ;
         READ:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request fields are captured only at grant; later input changes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last     <= IDX_W'(NREQ - 1);
         lat_we   <= 1'b0;
         lat_tag  <= '0;
         lat_data <= '0;
         gnt_r    <= '0;
         rdata_r  <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               lat_we   <= bus.we_in[winner];
               lat_tag  <= bus.tag_in[winner*TAG_W +: TAG_W];
               lat_data <= bus.data_in[winner*DATA_W +: DATA_W];
               gnt_r    <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
               last     <= winner;
            end
            READ:    rdata_r <= bus.mem_Q;
            DONE:    gnt_r   <= '0;
            default: ;
         endcase
      end
   end

   assign bus.gnt         = gnt_r;
   assign bus.done        = (state == DONE);
   assign bus.rdata       = rdata_r;
   assign bus.mem_tag     = lat_tag;
   assign bus.mem_data    = lat_data;
   // Decoded from state so an asynchronous reset drops it before the write edge.
   assign bus.mem_writeEn = (state == ACCESS) && lat_we;

`ifdef BUS_SNOOP_EN
   assign bus.snoop_valid = (state == ACCESS);
   assign bus.snoop_we    = (state == ACCESS) && lat_we;
   assign bus.snoop_tag   = (state == ACCESS) ? lat_tag : '0;
   assign bus.snoop_src   = (state == ACCESS) ? gnt_r : '0;
`else
   assign bus.snoop_valid = 1'b0;
   assign bus.snoop_we    = 1'b0;
   assign bus.snoop_tag   = '0;
   assign bus.snoop_src   = '0;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: per-cache drivers, a memory model, a
// round-robin reference model that fills the expected queue, and a negedge monitor.
module tb_mem_bus_arbiter;
   localparam int NREQ   = 3;
   localparam int TAG_W  = 2;
   localparam int DATA_W = 2;
   localparam int DEPTH  = 1 << TAG_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) bif ();

   mem_bus_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   logic              req_a  [NREQ];
   logic              we_a   [NREQ];
   logic [TAG_W-1:0]  tag_a  [NREQ];
   logic [DATA_W-1:0] data_a [NREQ];

   always_comb begin
      bif.req     = '0;
      bif.we_in   = '0;
      bif.tag_in  = '0;
      bif.data_in = '0;
      for (int i = 0; i < NREQ; i++) begin
         bif.req[i]                       = req_a[i];
         bif.we_in[i]                     = we_a[i];
         bif.tag_in[i*TAG_W +: TAG_W]     = tag_a[i];
         bif.data_in[i*DATA_W +: DATA_W]  = data_a[i];
      end
   end

   // Shared memory with registered read output; initial contents mem[i] = i.
   logic [DATA_W-1:0] mem [DEPTH];
   logic              mem_init = 1'b1;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
      end else if (bif.mem_writeEn) begin
         mem[bif.mem_tag] <= bif.mem_data;
      end
      bif.mem_Q <= mem[bif.mem_tag];
   end

   typedef struct {
      logic              we;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
      bit                glitch;
   } txn_t;

   typedef struct {
      int                src;
      logic              we;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] rdata;
   } exp_t;

   txn_t              tq [NREQ][$];
   exp_t              exp_q[$];
   logic [DATA_W-1:0] model_mem [DEPTH];
   int                model_last;
   int                checks   = 0;
   int                failures = 0;
   bit                mon_en   = 1'b0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic add(input int c, input int we, input int tag, input int data, input bit glitch);
      txn_t t;
      t.we     = 1'(we);
      t.tag    = TAG_W'(tag);
      t.data   = DATA_W'(data);
      t.glitch = glitch;
      tq[c].push_back(t);
   endtask

   // Reference: every cache with queued work is pending from the start of the batch;
   // each turn goes to the first pending cache after the previous winner.
   function automatic void plan_batch();
      int pos[NREQ];
      int left;
      left = 0;
      for (int c = 0; c < NREQ; c++) begin
         pos[c] = 0;
         left += tq[c].size();
      end
      while (left > 0) begin
         int   w;
         txn_t t;
         exp_t e;
         w = -1;
         for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (model_last + k) % NREQ;
            if (w < 0 && pos[c] < tq[c].size()) w = c;
         end
         t = tq[w][pos[w]];
         pos[w]++;
         left--;
         e.src  = w;
         e.we   = t.we;
         e.tag  = t.tag;
         e.data = t.data;
         e.rdata = model_mem[t.tag];
         if (t.we) model_mem[t.tag] = t.data;
         exp_q.push_back(e);
         model_last = w;
      end
   endfunction

   task automatic drive(input int c);
      int n;
      bit ok;
      for (int j = 0; j < tq[c].size(); j++) begin
         req_a[c]  = 1'b1;
         we_a[c]   = tq[c][j].we;
         tag_a[c]  = tq[c][j].tag;
         data_a[c] = tq[c][j].data;
         n = 0; ok = 1'b0;
         while (!ok && n < 400) begin
            @(negedge clk); n++;
            ok = bif.gnt[c];
         end
         if (!ok) begin
            checks++; failures++;
            $display("FAIL grant_timeout: cache %0d got no grant, required one within 400 cycles", c);
            req_a[c] = 1'b0;
            return;
         end
         if (tq[c][j].glitch) begin
            tag_a[c]  = ~tag_a[c];
            data_a[c] = ~data_a[c];
            we_a[c]   = ~we_a[c];
            req_a[c]  = 1'b0;
         end
         n = 0; ok = 1'b0;
         while (!ok && n < 10) begin
            @(negedge clk); n++;
            ok = bif.done && bif.gnt[c];
         end
         if (!ok) begin
            checks++; failures++;
            $display("FAIL done_timeout: cache %0d got no done, required one within 10 cycles", c);
            req_a[c] = 1'b0;
            return;
         end
      end
      req_a[c] = 1'b0;
   endtask

   task automatic run_batch();
      plan_batch();
      fork
         drive(0);
         drive(1);
         drive(2);
      join
      for (int c = 0; c < NREQ; c++) tq[c].delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic check_snoop_zero();
      check("snoop_valid_zero", int'(bif.snoop_valid), 0);
      check("snoop_we_zero",    int'(bif.snoop_we), 0);
      check("snoop_tag_zero",   int'(bif.snoop_tag), 0);
      check("snoop_src_zero",   int'(bif.snoop_src), 0);
   endtask

   // Monitor: the first cycle with a grant is the ACCESS cycle; done pops the scoreboard.
   initial begin
      int              cyc;
      int              acc_cyc;
      logic [NREQ-1:0] prev_gnt;
      bit              after_done;
      exp_t            f;
      cyc = 0; acc_cyc = 0; prev_gnt = '0; after_done = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (mon_en && !rst) begin
            if (bif.gnt != '0) check("gnt_onehot", $countones(bif.gnt), 1);
            if (prev_gnt == '0 && bif.gnt != '0) begin
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_grant: gnt=%b while nothing expected", bif.gnt);
               end else begin
                  f = exp_q[0];
                  acc_cyc = cyc;
                  check("grant_winner", int'(bif.gnt), 1 << f.src);
                  check("access_wen",   int'(bif.mem_writeEn), int'(f.we));
                  check("access_tag",   int'(bif.mem_tag), int'(f.tag));
                  if (f.we) check("access_data", int'(bif.mem_data), int'(f.data));
`ifdef BUS_SNOOP_EN
                  check("snoop_valid", int'(bif.snoop_valid), 1);
                  check("snoop_we",    int'(bif.snoop_we), int'(f.we));
                  check("snoop_tag",   int'(bif.snoop_tag), int'(f.tag));
                  check("snoop_src",   int'(bif.snoop_src), 1 << f.src);
`else
                  check_snoop_zero();
`endif
               end
            end else begin
               check("wen_outside_access", int'(bif.mem_writeEn), 0);
               check_snoop_zero();
            end
            if (bif.done) begin
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_done: done=1 while nothing expected");
               end else begin
                  f = exp_q.pop_front();
                  check("done_gnt",     int'(bif.gnt), 1 << f.src);
                  check("done_latency", cyc - acc_cyc, f.we ? 1 : 2);
                  if (!f.we) check("read_data", int'(bif.rdata), int'(f.rdata));
               end
               after_done = 1'b1;
            end else if (after_done) begin
               check("gnt_release", int'(bif.gnt), 0);
               after_done = 1'b0;
            end
         end
         prev_gnt = bif.gnt;
      end
   end

   initial begin
      int n;
      for (int c = 0; c < NREQ; c++) begin
         req_a[c] = 1'b0; we_a[c] = 1'b0; tag_a[c] = '0; data_a[c] = '0;
      end
      for (int i = 0; i < DEPTH; i++) model_mem[i] = DATA_W'(i);
      model_last = NREQ - 1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_gnt",   int'(bif.gnt), 0);
      check("rst_done",  int'(bif.done), 0);
      check("rst_rdata", int'(bif.rdata), 0);
      check("rst_tag",   int'(bif.mem_tag), 0);
      check("rst_data",  int'(bif.mem_data), 0);
      check("rst_wen",   int'(bif.mem_writeEn), 0);
      check_snoop_zero();
      mem_init = 1'b0;
      rst      = 1'b0;
      mon_en   = 1'b1;
      @(negedge clk);

      add(1, 1, 2, 1, 1'b0); run_batch();
      add(1, 1, 1, 2, 1'b0); run_batch();
      add(0, 0, 2, 0, 1'b0); run_batch();
      add(0, 0, 3, 0, 1'b0); run_batch();
      // Simultaneous held reads: cache 0 holds req for a second turn.
      add(0, 0, 1, 0, 1'b0); add(1, 0, 2, 0, 1'b0); add(2, 0, 3, 0, 1'b0);
      add(0, 0, 2, 0, 1'b0); run_batch();
      // Inputs change and req drops during ACCESS.
      add(2, 0, 1, 0, 1'b1); run_batch();
      add(2, 1, 3, 2, 1'b1); run_batch();

      // Reset during the ACCESS of a write to tag 0.
      mon_en    = 1'b0;
      req_a[0]  = 1'b1; we_a[0] = 1'b1; tag_a[0] = '0; data_a[0] = 2'b11;
      n = 0;
      while (!bif.gnt[0] && n < 20) begin
         @(negedge clk); n++;
      end
      check("abort_grant", int'(bif.gnt[0]), 1);
      check("abort_wen_before", int'(bif.mem_writeEn), 1);
      rst = 1'b1;
      #1;
      check("abort_wen_after", int'(bif.mem_writeEn), 0);
      check("abort_gnt_after", int'(bif.gnt), 0);
      req_a[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_no_done", int'(bif.done), 0);
      end
      rst = 1'b0;
      model_last = NREQ - 1;
      @(negedge clk);
      mon_en = 1'b1;
      add(1, 0, 0, 0, 1'b0); add(0, 0, 3, 0, 1'b0); run_batch();

      for (int b = 0; b < 40; b++) begin
         int mask;
         mask = int'($urandom_range(1, 7));
         for (int c = 0; c < NREQ; c++) begin
            if (mask[c]) begin
               int nt;
               nt = int'($urandom_range(1, 2));
               for (int k = 0; k < nt; k++)
                  add(c, int'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)),
                      int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
            end
         end
         run_batch();
      end

      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
